baggage_drop_ctrl: RTL and testbench
====================================

BAGGAGE_DROP_CTRL -- requirements
Module: baggage_drop_ctrl

Interface
REQ-001 The block SHALL have parameter OK_SAMPLES, default 4, meaning the number of consecutive in-limit samples required before a drop.
REQ-002 The block SHALL have parameter DROP_CYCLES, default 16, meaning the number of cycles drop_en is held during a drop.
REQ-003 The block SHALL have parameter ACQ_TIMEOUT, default 1024, meaning the maximum number of ACQ cycles before a fault.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a drop sequence.
REQ-007 The block SHALL have port abort, input, 1 bit: cancel the sequence or clear a fault.
REQ-008 The block SHALL have port sensor_valid, input, 1 bit: sensor_temp is valid this cycle.
REQ-009 The block SHALL have port sensor_temp, input, 16 bits: temperature sample, unsigned.
REQ-010 The block SHALL have port lim_cfg, input, 16 bits: temperature limit, unsigned.
REQ-011 The block SHALL have port drop_activated, input, 1 bit: feedback from the display/drop datapath.
REQ-012 The block SHALL have port drop_en, output, 1 bit: enable to the display/drop datapath.
REQ-013 The block SHALL have port t_act, output, 16 bits: registered sample driven to the datapath.
REQ-014 The block SHALL have port t_lim, output, 16 bits: registered limit driven to the datapath.
REQ-015 The block SHALL have ports busy, done and fault, outputs, 1 bit each: status.

Function
REQ-016 The FSM SHALL have states IDLE, ACQ, ARM, DROP, HOT and TOUT.
REQ-017 All outputs SHALL be registered or decoded from the state register only, with no combinational path from any input to any output.
REQ-018 IDLE: drop_en=0, busy=0, t_act=0; when start=1, the block SHALL latch lim_cfg into t_lim, clear all counters and enter ACQ.
REQ-019 ACQ: busy=1 and drop_en=0; on each sensor_valid the block SHALL latch sensor_temp into t_act.
REQ-020 In ACQ, a sample <= t_lim SHALL increment ok_cnt, and a sample > t_lim SHALL clear ok_cnt to 0.
REQ-021 In ACQ, when ok_cnt reaches OK_SAMPLES the block SHALL enter ARM on the next cycle.
REQ-022 In ACQ, the cycle counter SHALL advance every cycle spent in ACQ; if it reaches ACQ_TIMEOUT before ARM, the block SHALL enter TOUT.
REQ-023 If the OK_SAMPLES-th in-limit sample and the timeout occur in the same cycle, ARM SHALL win.
REQ-024 ARM lasts one cycle with drop_en=1; if drop_activated=1 the block SHALL enter DROP, else HOT.
REQ-025 DROP: drop_en=1 SHALL be held for exactly DROP_CYCLES cycles, counted from DROP entry.
REQ-026 In DROP, sensor_valid samples SHALL still update t_act.
REQ-027 In DROP, a sample > t_lim SHALL cause entry to HOT on the next cycle.
REQ-028 At DROP completion the block SHALL pulse done=1 for one cycle, set drop_en=0 and t_act=0, and return to IDLE.
REQ-029 If a hot sample arrives in the final DROP cycle, HOT SHALL take precedence over done.
REQ-030 HOT: drop_en=1 and fault=1, with t_act holding the offending sample so the datapath shows HOT; start SHALL be ignored.
REQ-031 TOUT: drop_en=0 and fault=1; start SHALL be ignored.
REQ-032 abort=1 in any state SHALL force IDLE on the next cycle, with drop_en=0, t_act=0, done=0 and fault=0.
REQ-033 abort SHALL have priority over start and over every other transition.
REQ-034 start while busy SHALL be ignored, and t_lim SHALL change only on accepted start.
REQ-035 ok_cnt SHALL saturate at OK_SAMPLES, and each counter SHALL be sized as clog2(parameter)+1 bits.
REQ-036 Comparisons SHALL be 16-bit unsigned, with equality counting as in-limit.

Reset
REQ-037 On rst_n=0 the block SHALL immediately, without waiting for a clock edge, enter IDLE and set drop_en=0, t_act=0, t_lim=0, busy=0, done=0, fault=0 and all counters to 0.
REQ-038 Reset in mid-DROP SHALL deassert drop_en immediately.
REQ-039 After rst_n rises, the first start SHALL be accepted on the first rising clk edge.

Verification
REQ-040 Nominal: lim_cfg=500, start, then 4 valid samples of 300 -> ARM; with drop_activated=1 -> DROP, drop_en=1 for 16 cycles, then done pulse, back in IDLE with t_act=0.
REQ-041 Restart count: samples 300, 300, 600, 300, 300, 300, 300 -> ARM entered only after the 7th sample; a sample of 500 counts as OK.
REQ-042 Hot mid-drop: sample 700 in DROP cycle 5 -> HOT next cycle, drop_en=1, fault=1, t_act=700; start ignored; abort -> IDLE, fault=0.
REQ-043 Timeout: no sensor_valid for 1024 ACQ cycles -> TOUT, fault=1, drop_en=0; abort clears it.
REQ-044 Priority: start and abort together in IDLE -> stays IDLE; abort during ACQ -> IDLE next cycle.
REQ-045 Reset: rst_n low in DROP cycle 8, asynchronous to clk -> drop_en=0 at once, all outputs at reset values, and start accepted after release.

Source files
------------

// File: rtl/baggage_drop_ctrl.sv
// baggage_drop_ctrl
//   Sequences a baggage drop. A start request latches the temperature limit.
//   The block then waits for OK_SAMPLES consecutive in-limit sensor samples,
//   arms the drop datapath for one cycle and holds the drop enable for
//   DROP_CYCLES cycles. It faults to HOT on an over-limit sample or a missing
//   activation, and to TOUT when acquisition takes too long.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        sequence request / cancel (abort also clears faults)
//   sensor_valid        qualifies sensor_temp
//   sensor_temp         16-bit unsigned temperature sample
//   lim_cfg             16-bit unsigned temperature limit, latched on start
//   drop_activated      datapath feedback, sampled in ARM
//   drop_en             enable to the display/drop datapath
//   t_act, t_lim        registered sample / limit to the datapath
//   busy, done, fault   status (done is a one-cycle pulse)
module baggage_drop_ctrl #(
   parameter int OK_SAMPLES  = 4,
   parameter int DROP_CYCLES = 16,
   parameter int ACQ_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        sensor_valid,
   input  logic [15:0] sensor_temp,
   input  logic [15:0] lim_cfg,
   input  logic        drop_activated,
   output logic        drop_en,
   output logic [15:0] t_act,
   output logic [15:0] t_lim,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   localparam int OKW   = $clog2(OK_SAMPLES) + 1;
   localparam int DROPW = $clog2(DROP_CYCLES) + 1;
   localparam int ACQW  = $clog2(ACQ_TIMEOUT) + 1;

   localparam logic [OKW-1:0]   OK_MAX   = OKW'(OK_SAMPLES);
   localparam logic [DROPW-1:0] DROP_MAX = DROPW'(DROP_CYCLES);
   localparam logic [ACQW-1:0]  ACQ_MAX  = ACQW'(ACQ_TIMEOUT);

   typedef enum logic [2:0] {IDLE, ACQ, ARM, DROP, HOT, TOUT} state_t;

   state_t           state;
   logic [OKW-1:0]   ok_cnt;
   logic [DROPW-1:0] drop_cnt;
   logic [ACQW-1:0]  acq_cnt;

   logic [OKW-1:0]   ok_inc;
   logic [DROPW-1:0] drop_inc;
   logic [ACQW-1:0]  acq_inc;
   logic             hot_smp;
   logic             arm_now;

   always_comb begin
      // ok_cnt saturates so it can never wrap past the threshold
      ok_inc   = (ok_cnt == OK_MAX) ? ok_cnt : ok_cnt + 1'b1;
      drop_inc = drop_cnt + 1'b1;
      acq_inc  = acq_cnt + 1'b1;
      hot_smp  = sensor_valid && (sensor_temp > t_lim);
      arm_now  = sensor_valid && !hot_smp && (ok_inc == OK_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ok_cnt   <= '0;
         drop_cnt <= '0;
         acq_cnt  <= '0;
         drop_en  <= 1'b0;
         t_act    <= '0;
         t_lim    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         fault    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            // abort beats every other transition; t_lim only moves on start
            state   <= IDLE;
            drop_en <= 1'b0;
            t_act   <= '0;
            busy    <= 1'b0;
            fault   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state    <= ACQ;
                     t_lim    <= lim_cfg;
                     ok_cnt   <= '0;
                     drop_cnt <= '0;
                     acq_cnt  <= '0;
                     busy     <= 1'b1;
                  end
               end
               ACQ: begin
                  acq_cnt <= acq_inc;
                  if (sensor_valid) begin
                     t_act  <= sensor_temp;
                     ok_cnt <= hot_smp ? '0 : ok_inc;
                  end
                  // the final good sample wins over a coincident timeout
                  if (arm_now) begin
                     state   <= ARM;
                     drop_en <= 1'b1;
                  end else if (acq_inc == ACQ_MAX) begin
                     state <= TOUT;
                     busy  <= 1'b0;
                     fault <= 1'b1;
                  end
               end
               ARM: begin
                  if (drop_activated) begin
                     state    <= DROP;
                     drop_cnt <= '0;
                  end else begin
                     state <= HOT;
                     busy  <= 1'b0;
                     fault <= 1'b1;
                  end
               end
               DROP: begin
                  drop_cnt <= drop_inc;
                  if (sensor_valid) t_act <= sensor_temp;
                  // a hot sample in the last cycle still faults instead of done
                  if (hot_smp) begin
                     state <= HOT;
                     busy  <= 1'b0;
                     fault <= 1'b1;
                  end else if (drop_inc == DROP_MAX) begin
                     state   <= IDLE;
                     drop_en <= 1'b0;
                     t_act   <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
               HOT, TOUT: ;  // held until abort
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
module tb_baggage_drop_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        sensor_valid = 1'b0;
   logic [15:0] sensor_temp = '0;
   logic [15:0] lim_cfg = '0;
   logic        drop_activated = 1'b1;
   logic        drop_en;
   logic [15:0] t_act;
   logic [15:0] t_lim;
   logic        busy;
   logic        done;
   logic        fault;

   int tests = 0;
   int fails = 0;

   baggage_drop_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .sensor_valid(sensor_valid), .sensor_temp(sensor_temp),
      .lim_cfg(lim_cfg), .drop_activated(drop_activated),
      .drop_en(drop_en), .t_act(t_act), .t_lim(t_lim),
      .busy(busy), .done(done), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // status bundle {drop_en, busy, done, fault}
   task automatic chk_st(input string tag, input logic [3:0] exp);
      chk(tag, {12'd0, drop_en, busy, done, fault}, {12'd0, exp});
   endtask

   task automatic go(input logic [15:0] lim);
      lim_cfg = lim;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic sample(input logic [15:0] t);
      sensor_valid = 1'b1;
      sensor_temp = t;
      tick();
      sensor_valid = 1'b0;
   endtask

   // 4 good samples then the ARM cycle; leaves the bench in DROP cycle 1
   task automatic to_drop();
      go(16'd500);
      repeat (4) sample(16'd300);
      tick();
   endtask

   initial begin
      int n;
      #2;
      chk_st("reset_status", 4'b0000);
      chk("reset_t_act", t_act, 16'd0);
      chk("reset_t_lim", t_lim, 16'd0);
      #10 rst_n = 1'b1;

      // nominal
      go(16'd500);
      chk_st("acq_status", 4'b0100);
      chk("acq_t_lim", t_lim, 16'd500);
      sample(16'd300);
      chk("acq_t_act", t_act, 16'd300);
      repeat (2) sample(16'd300);
      chk_st("acq_3_samples", 4'b0100);
      sample(16'd300);
      chk_st("arm_status", 4'b1100);
      tick();
      n = 0;
      while (drop_en && n < 40) begin
         n++;
         tick();
      end
      chk("drop_len", 16'(n), 16'd16);
      chk_st("done_pulse", 4'b0010);
      chk("done_t_act", t_act, 16'd0);
      tick();
      chk_st("idle_after_done", 4'b0000);

      // restart count, 500 == limit counts as OK, ARM without activation -> HOT
      go(16'd500);
      sample(16'd300); sample(16'd300); sample(16'd600);
      chk("hot_sample_t_act", t_act, 16'd600);
      sample(16'd300); sample(16'd300); sample(16'd300);
      chk_st("no_arm_after_6", 4'b0100);
      sample(16'd500);
      chk_st("arm_after_7", 4'b1100);
      drop_activated = 1'b0;
      tick();
      drop_activated = 1'b1;
      chk_st("arm_no_act_hot", 4'b1001);
      abort = 1'b1; tick(); abort = 1'b0;
      chk_st("abort_hot", 4'b0000);

      // hot sample in DROP cycle 5
      to_drop();
      repeat (4) tick();
      chk_st("drop_cyc5", 4'b1100);
      sample(16'd700);
      chk_st("hot_status", 4'b1001);
      chk("hot_t_act", t_act, 16'd700);
      lim_cfg = 16'd900;
      start = 1'b1; tick(); start = 1'b0;
      chk_st("hot_ignores_start", 4'b1001);
      chk("hot_t_lim_kept", t_lim, 16'd500);
      abort = 1'b1; tick(); abort = 1'b0;
      chk_st("hot_abort", 4'b0000);
      chk("hot_abort_t_act", t_act, 16'd0);

      // hot sample in the final DROP cycle beats done
      to_drop();
      repeat (15) tick();
      sample(16'd800);
      chk_st("last_cyc_hot", 4'b1001);
      abort = 1'b1; tick(); abort = 1'b0;

      // timeout
      go(16'd500);
      repeat (1023) tick();
      chk_st("acq_before_tout", 4'b0100);
      tick();
      chk_st("tout_status", 4'b0001);
      start = 1'b1; tick(); start = 1'b0;
      chk_st("tout_ignores_start", 4'b0001);
      abort = 1'b1; tick(); abort = 1'b0;
      chk_st("tout_abort", 4'b0000);

      // priority
      lim_cfg = 16'd123;
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      chk_st("start_abort_idle", 4'b0000);
      chk("start_abort_t_lim", t_lim, 16'd500);
      go(16'd500);
      abort = 1'b1; tick(); abort = 1'b0;
      chk_st("abort_in_acq", 4'b0000);

      // asynchronous reset in DROP cycle 8
      to_drop();
      repeat (7) tick();
      chk_st("drop_cyc8", 4'b1100);
      #3 rst_n = 1'b0;
      #1;
      chk_st("async_rst_status", 4'b0000);
      chk("async_rst_t_act", t_act, 16'd0);
      chk("async_rst_t_lim", t_lim, 16'd0);
      #2 rst_n = 1'b1;
      go(16'd321);
      chk_st("start_after_rst", 4'b0100);
      chk("t_lim_after_rst", t_lim, 16'd321);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
